// File: rtl/ir_fetch_queue.sv
// ir_fetch_queue: architectural instruction register loaded from a flushable queue of PC-tagged prefetched words
module ir_fetch_queue #(
    parameter int WIDTH = 16,
    parameter int PC_W  = 16,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_instr,
    input  logic [PC_W-1:0]  wr_pc,
    input  logic             ld_ir,
    output logic             head_vld,
    output logic [WIDTH-1:0] ir,
    output logic [PC_W-1:0]  ir_pc,
    output logic             ir_valid,
    output logic [3:0]       opcode,
    output logic [CW-1:0]    count
);
    logic [WIDTH+PC_W-1:0] mem_q [DEPTH];
    logic [WIDTH+PC_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [WIDTH-1:0]      ir_q, ir_d;
    logic [PC_W-1:0]       ir_pc_q, ir_pc_d;
    logic                  ir_valid_q, ir_valid_d;
    logic                  push, pop;

    always_comb begin
        head_vld   = count_q != '0;
        wr_ready   = (count_q != CW'(DEPTH)) && !flush;
        push       = wr_valid && wr_ready;
        pop        = ld_ir && head_vld && !flush;
        mem_d      = mem_q;
        if (push) mem_d[wr_ptr_q] = {wr_instr, wr_pc};
        wr_ptr_d   = flush ? '0 : wr_ptr_q + AW'(push);
        rd_ptr_d   = flush ? '0 : rd_ptr_q + AW'(pop);
        count_d    = flush ? '0 : count_q + CW'(push) - CW'(pop);
        {ir_d, ir_pc_d} = pop ? mem_q[rd_ptr_q] : {ir_q, ir_pc_q};
        ir_valid_d = !flush && (pop || ir_valid_q);
    end

    // storage is never read unless count says the entry was written, so it needs no reset
    always_ff @(posedge clk) mem_q <= mem_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    assign ir       = ir_q;
    assign ir_pc    = ir_pc_q;
    assign ir_valid = ir_valid_q;
    assign opcode   = ir_q[WIDTH-1 -: 4];
    assign count    = count_q;
endmodule

// File: tb/tb_ir_fetch_queue.sv
// tb_ir_fetch_queue: directed scenarios plus random traffic against a queue-based reference model
module tb_ir_fetch_queue;
    localparam int DEPTH = 4;
    logic        clk = 0, reset = 0, flush = 0, wr_valid = 0, ld_ir = 0;
    logic [15:0] wr_instr = 0, wr_pc = 0;
    logic        wr_ready, head_vld, ir_valid;
    logic [15:0] ir, ir_pc;
    logic [3:0]  opcode;
    logic [2:0]  count;
    int          n_cmp = 0, n_bad = 0;
    logic [31:0] m_q[$];
    logic [15:0] m_ir = 0, m_pc = 0;
    logic        m_vld = 0;

    ir_fetch_queue #(.WIDTH(16), .PC_W(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_instr(wr_instr), .wr_pc(wr_pc), .ld_ir(ld_ir), .head_vld(head_vld), .ir(ir),
        .ir_pc(ir_pc), .ir_valid(ir_valid), .opcode(opcode), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all();
        chk("count", 32'(count), 32'(m_q.size()));
        chk("head_vld", 32'(head_vld), 32'(m_q.size() != 0));
        chk("ir", 32'(ir), 32'(m_ir));
        chk("ir_pc", 32'(ir_pc), 32'(m_pc));
        chk("ir_valid", 32'(ir_valid), 32'(m_vld));
        chk("opcode", 32'(opcode), 32'(m_ir >> 12));
    endtask

    task automatic cycle(input logic f, input logic wv, input logic [15:0] wi, input logic [15:0] wp,
                         input logic l);
        logic [31:0] e;
        bit can_push;
        flush = f; wr_valid = wv; wr_instr = wi; wr_pc = wp; ld_ir = l;
        #1;
        can_push = m_q.size() < DEPTH;
        chk("wr_ready", 32'(wr_ready), 32'(can_push && !f));
        @(posedge clk);
        if (f) begin
            m_q.delete();
            m_vld = 0;
        end else begin
            if (l && m_q.size() > 0) begin
                e = m_q.pop_front();
                m_ir = e[31:16]; m_pc = e[15:0]; m_vld = 1;
            end
            if (wv && can_push) m_q.push_back({wi, wp});
        end
        #1;
        chk_all();
    endtask

    task automatic async_reset();
        flush = 0; wr_valid = 0; ld_ir = 0;
        #2 reset = 1;
        #1;
        m_q.delete(); m_ir = 0; m_pc = 0; m_vld = 0;
        chk_all();
        @(negedge clk) reset = 0;
        #1 chk("wr_ready_rst", 32'(wr_ready), 32'd1);
    endtask

    initial begin
        async_reset();
        // mid-stream reset with three words queued
        for (int i = 0; i < 3; i++) cycle(0, 1, 16'h7000 + 16'(i), 16'h2000 + 16'(i), 0);
        chk("pre_rst_cnt", 32'(count), 32'd3);
        async_reset();
        chk("rst_cnt", 32'(count), 32'd0);
        chk("rst_ir", 32'(ir), 32'h0);
        // order and latency
        cycle(0, 1, 16'h5020, 16'h3000, 0);
        cycle(0, 0, 16'h0, 16'h0, 1);
        chk("lat_ir", 32'(ir), 32'h5020);
        chk("lat_pc", 32'(ir_pc), 32'h3000);
        chk("lat_op", 32'(opcode), 32'h5);
        // fill, then a fifth push that must be dropped
        for (int i = 0; i < 5; i++) cycle(0, 1, 16'h1201 + 16'(i), 16'h3000 + 16'(i), 0);
        chk("fill_cnt", 32'(count), 32'd4);
        chk("fill_rdy", 32'(wr_ready), 32'd0);
        // concurrent push+load when full pops only, then both take effect
        cycle(0, 1, 16'hAAAA, 16'h4000, 1);
        chk("conc_cnt", 32'(count), 32'd3);
        chk("conc_ir", 32'(ir), 32'h1201);
        cycle(0, 1, 16'hBBBB, 16'h4001, 1);
        chk("conc2_cnt", 32'(count), 32'd3);
        // flush with ld_ir held: queue empties, ir holds, ir_valid drops
        cycle(1, 1, 16'hCCCC, 16'h4002, 1);
        chk("fl_cnt", 32'(count), 32'd0);
        chk("fl_ir", 32'(ir), 32'h1202);
        chk("fl_vld", 32'(ir_valid), 32'd0);
        // wrap through the pointers several times
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 16'h9000 + 16'(i), 16'h5000 + 16'(i), 0);
            cycle(0, 0, 16'h0, 16'h0, 1);
            chk("wrap_ir", 32'(ir), 32'h9000 + 32'(i));
        end
        cycle(0, 0, 16'h0, 16'h0, 1);
        chk("empty_ld_ir", 32'(ir), 32'h9009);
        // random traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) async_reset();
            else cycle($urandom_range(0, 19) == 0, 1'($urandom), 16'($urandom), 16'($urandom),
                       $urandom_range(0, 2) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
